// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired control sequencer: fetch, decode, ALU/load/store execute, memory wait timeout
module control_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    output logic        pco,
    output logic        iro,
    output logic        maro,
    output logic        mdro,
    output logic        rzo,
    output logic        r0o,
    output logic        r1o,
    output logic        pci,
    output logic        iri,
    output logic        mari,
    output logic        mdri,
    output logic        ryi,
    output logic        rzi,
    output logic        r0i,
    output logic        r1i,
    output logic        mdr_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        pc_inc,
    output logic [4:0]  alu_op,
    output logic        halted,
    output logic        fault,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE} kind_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    kind_t      kind, dec_kind;
    logic [7:0] wait_cnt;

    logic [4:0] opcode;
    logic       is_alu, is_load, is_store, is_halt;
    logic       in_wait, timed_out;
    logic       unused_ir_bits;

    assign opcode   = ir[31:27];
    assign is_alu   = (opcode == 5'd3) || (opcode == 5'd4) || (opcode == 5'd5) || (opcode == 5'd6);
    assign is_load  = (opcode == 5'd0);
    assign is_store = (opcode == 5'd1);
    assign is_halt  = (opcode == 5'd31);
    assign dec_kind = is_load ? K_LOAD : (is_store ? K_STORE : K_ALU);

    // The operand field below rb is never interpreted by the sequencer.
    assign unused_ir_bits = ^ir[23:0];

    // Memory wait states: fetch read, load read, store write.
    assign in_wait   = (state == S_F1)
                    || ((state == S_E1) && (kind == K_LOAD))
                    || ((state == S_E2) && (kind == K_STORE));
    assign timed_out = in_wait && !mem_ack && (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction class latched at decode; wait counter restarts on every state change.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            kind     <= K_ALU;
            wait_cnt <= 8'd0;
        end else begin
            if (state == S_DEC) begin
                kind <= dec_kind;
            end
            if (state_next != state) begin
                wait_cnt <= 8'd0;
            end else if (in_wait && !mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (run) state_next = S_F0;
            S_F0:    state_next = S_F1;
            S_F1: begin
                if (mem_ack)        state_next = S_F2;
                else if (timed_out) state_next = S_FAULT;
            end
            S_F2:    state_next = S_DEC;
            S_DEC: begin
                if (is_alu || is_load || is_store) state_next = S_E0;
                else if (is_halt)                  state_next = S_HALT;
                else                               state_next = run ? S_F0 : S_IDLE;
            end
            S_E0:    state_next = S_E1;
            S_E1: begin
                if ((kind != K_LOAD) || mem_ack) state_next = S_E2;
                else if (timed_out)              state_next = S_FAULT;
            end
            S_E2: begin
                if ((kind != K_STORE) || mem_ack) state_next = run ? S_F0 : S_IDLE;
                else if (timed_out)               state_next = S_FAULT;
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    // Control outputs; mdri during memory reads follows mem_ack in the same cycle.
    always_comb begin
        pco = 1'b0; iro = 1'b0; maro = 1'b0; mdro = 1'b0; rzo = 1'b0; r0o = 1'b0; r1o = 1'b0;
        pci = 1'b0; iri = 1'b0; mari = 1'b0; mdri = 1'b0; ryi = 1'b0; rzi = 1'b0;
        r0i = 1'b0; r1i = 1'b0;
        mdr_sel = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; pc_inc = 1'b0; alu_op = 5'd0;
        halted = 1'b0; fault = 1'b0; illegal = 1'b0;
        case (state)
            S_F0: begin
                pco = 1'b1; mari = 1'b1; pc_inc = 1'b1;
            end
            S_F1: begin
                mem_rd = 1'b1; mdri = mem_ack;
            end
            S_F2: begin
                mdro = 1'b1; iri = 1'b1;
            end
            S_DEC: illegal = !(is_alu || is_load || is_store || is_halt);
            S_E0: begin
                r0o = !ir[25]; r1o = ir[25];
                if (kind == K_ALU) ryi = 1'b1;
                else               mari = 1'b1;
            end
            S_E1: begin
                case (kind)
                    K_ALU: begin
                        r0o = !ir[24]; r1o = ir[24]; rzi = 1'b1; alu_op = opcode;
                    end
                    K_LOAD: begin
                        mem_rd = 1'b1; mdri = mem_ack;
                    end
                    default: begin
                        r0o = !ir[24]; r1o = ir[24]; mdri = 1'b1; mdr_sel = 1'b1;
                    end
                endcase
            end
            S_E2: begin
                case (kind)
                    K_ALU: begin
                        rzo = 1'b1; r0i = !ir[26]; r1i = ir[26];
                    end
                    K_LOAD: begin
                        mdro = 1'b1; r0i = !ir[26]; r1i = ir[26];
                    end
                    default: mem_wr = 1'b1;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized and directed checks of control_unit against an instruction-level model
module tb_control_unit;

    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic pco, iro, maro, mdro, rzo, r0o, r1o;
        logic pci, iri, mari, mdri, ryi, rzi, r0i, r1i;
        logic mdr_sel, mem_rd, mem_wr, pc_inc;
        logic [4:0] alu_op;
        logic halted, fault, illegal;
    } ov_t;

    logic clock, clear, run, mem_ack;
    logic [31:0] ir;
    logic pco, iro, maro, mdro, rzo, r0o, r1o;
    logic pci, iri, mari, mdri, ryi, rzi, r0i, r1i;
    logic mdr_sel, mem_rd, mem_wr, pc_inc, halted, fault, illegal;
    logic [4:0] alu_op;
    ov_t dut_v;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 fetch (step 0 addr, 1 read, 2 ir load, 3 decode), 2 execute (step 0..2), 3 halted, 4 fault
    int m_mode = 0, m_step = 0, m_waits = 0, m_cls = 0;

    int ack_mode = 2;   // 0 random, 1 ack after ack_delay request cycles, 2 never
    int ack_delay = 2;
    int wait_k = 0;

    control_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ack(mem_ack),
        .pco(pco), .iro(iro), .maro(maro), .mdro(mdro), .rzo(rzo), .r0o(r0o), .r1o(r1o),
        .pci(pci), .iri(iri), .mari(mari), .mdri(mdri), .ryi(ryi), .rzi(rzi), .r0i(r0i), .r1i(r1i),
        .mdr_sel(mdr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_inc(pc_inc), .alu_op(alu_op),
        .halted(halted), .fault(fault), .illegal(illegal)
    );

    assign dut_v = {pco, iro, maro, mdro, rzo, r0o, r1o, pci, iri, mari, mdri, ryi, rzi, r0i, r1i,
                    mdr_sel, mem_rd, mem_wr, pc_inc, alu_op, halted, fault, illegal};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // 0 alu, 1 load, 2 store, -1 anything else
    function automatic int classify(input logic [4:0] op);
        case (op)
            5'd0: return 1;
            5'd1: return 2;
            5'd3, 5'd4, 5'd5, 5'd6: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic ov_t model_out(input int mode, input int step, input int cls,
                                      input logic [31:0] v, input logic ack);
        ov_t e;
        e = '0;
        if (mode == 1) begin
            if (step == 0) begin e.pco = 1; e.mari = 1; e.pc_inc = 1; end
            else if (step == 1) begin e.mem_rd = 1; e.mdri = ack; end
            else if (step == 2) begin e.mdro = 1; e.iri = 1; end
            else e.illegal = (classify(v[31:27]) < 0) && (v[31:27] != 5'd31);
        end else if (mode == 2) begin
            if (step == 0) begin
                if (v[25]) e.r1o = 1; else e.r0o = 1;
                if (cls == 0) e.ryi = 1; else e.mari = 1;
            end else if (step == 1) begin
                if (cls == 1) begin
                    e.mem_rd = 1; e.mdri = ack;
                end else begin
                    if (v[24]) e.r1o = 1; else e.r0o = 1;
                    if (cls == 0) begin e.rzi = 1; e.alu_op = v[31:27]; end
                    else begin e.mdri = 1; e.mdr_sel = 1; end
                end
            end else begin
                if (cls == 2) e.mem_wr = 1;
                else begin
                    if (cls == 0) e.rzo = 1; else e.mdro = 1;
                    if (v[26]) e.r1i = 1; else e.r0i = 1;
                end
            end
        end else if (mode == 3) e.halted = 1;
        else if (mode == 4) e.fault = 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare every cycle at the falling edge, then advance the model by one clock.
    initial begin
        ov_t exp;
        int c;
        forever begin
            @(negedge clock or negedge clear);
            if (!clear) begin
                m_mode = 0; m_step = 0; m_waits = 0;
            end else if (!clock) begin
                exp = model_out(m_mode, m_step, m_cls, ir, mem_ack);
                checks++;
                if (dut_v !== exp) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t mode=%0d step=%0d got=%h want=%h",
                             $time, m_mode, m_step, dut_v, exp);
                end
                checks++;
                if ($countones({pco, iro, maro, mdro, rzo, r0o, r1o}) > 1) begin
                    errors++;
                    $display("FAIL bus_onehot t=%0t got=%b want at most one",
                             $time, {pco, iro, maro, mdro, rzo, r0o, r1o});
                end
                case (m_mode)
                    0: if (run) begin m_mode = 1; m_step = 0; end
                    1: begin
                        if (m_step == 0) begin m_step = 1; m_waits = 0; end
                        else if (m_step == 1) begin
                            if (mem_ack) m_step = 2;
                            else begin m_waits++; if (m_waits == TIMEOUT) m_mode = 4; end
                        end else if (m_step == 2) m_step = 3;
                        else begin
                            c = classify(ir[31:27]);
                            if (c >= 0) begin m_mode = 2; m_step = 0; m_cls = c; end
                            else if (ir[31:27] == 5'd31) m_mode = 3;
                            else begin m_mode = run ? 1 : 0; m_step = 0; end
                        end
                    end
                    2: begin
                        if (m_step == 0) begin m_step = 1; m_waits = 0; end
                        else if (m_step == 1) begin
                            if (m_cls != 1 || mem_ack) begin m_step = 2; m_waits = 0; end
                            else begin m_waits++; if (m_waits == TIMEOUT) m_mode = 4; end
                        end else begin
                            if (m_cls != 2 || mem_ack) begin m_mode = run ? 1 : 0; m_step = 0; end
                            else begin m_waits++; if (m_waits == TIMEOUT) m_mode = 4; end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory responder.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (ack_mode == 0) begin
                mem_ack = ($urandom_range(0, 99) < 40);
            end else if (ack_mode == 1 && (mem_rd || mem_wr)) begin
                wait_k++;
                mem_ack = (wait_k >= ack_delay);
            end else begin
                wait_k = 0;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
    endtask

    initial begin
        int alu_cnt, alu_val, saw_a, saw_b, saw_c, cnt, found, changes;
        ov_t halt_v;
        logic [31:0] r;
        logic [4:0] op_tab [9];
        op_tab = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd2, 5'd7, 5'd20};

        clear = 1'b0; run = 1'b0; ir = 32'h0;
        @(negedge clock);
        chk("reset_outputs", 32'(dut_v), 32'h0);
        tick();
        clear = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_until_run", 32'(dut_v), 32'h0);

        // add r0,r0,r0 with run dropped after the start: instruction completes then idles
        tick();
        ir = 32'h1800_0000; run = 1'b1; ack_mode = 1;
        tick();
        run = 1'b0;
        alu_cnt = 0; alu_val = 0; saw_a = 0; cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (alu_op != 0) begin alu_cnt++; alu_val = alu_op; end
            if (rzo && r0i) saw_a++;
            if (pco) cnt++;
        end
        chk("add_alu_cycles", alu_cnt, 1);
        chk("add_alu_op", alu_val, 3);
        chk("add_rzo_r0i", saw_a, 1);
        chk("add_single_fetch", cnt, 1);
        chk("add_ends_idle", 32'(dut_v), 32'h0);

        // store ra=r0 rb=r1
        tick();
        ir = 32'h0D00_0000; run = 1'b1;
        tick();
        run = 1'b0;
        saw_a = 0; saw_b = 0; cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (r0o && mari && !pco) saw_a++;
            if (r1o && mdri && mdr_sel) saw_b++;
            if (mem_wr) cnt++;
        end
        chk("store_e0_r0o_mari", saw_a, 1);
        chk("store_e1_r1o_mdri_sel", saw_b, 1);
        chk("store_mem_wr_cycles", cnt, 2);

        // illegal opcode 00111
        tick();
        ir = 32'h3800_0000; run = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock);
            if (illegal) begin
                found = 1;
                chk("illegal_no_loads", {pci, iri, mari, mdri, ryi, rzi, r0i, r1i}, 0);
                @(negedge clock);
                chk("illegal_next_f0", pco, 1);
                chk("illegal_one_cycle", illegal, 0);
            end
        end
        chk("illegal_seen", found, 1);
        tick();
        run = 1'b0;
        repeat (12) @(negedge clock);
        chk("illegal_then_idle", 32'(dut_v), 32'h0);

        // randomized traffic; ir only changes outside the execute phase
        ack_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            run = ($urandom_range(0, 99) < 90);
            if (m_mode != 2) begin
                r = $urandom;
                ir = {op_tab[$urandom_range(0, 8)], r[26:0]};
            end
        end

        // fetch timeout
        run = 1'b0; ack_mode = 2;
        do_reset();
        ir = 32'h1800_0000; run = 1'b1;
        tick();
        run = 1'b0;
        cnt = 0; found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clock);
            if (mem_rd) cnt++;
            if (fault) found = 1;
        end
        chk("timeout_wait_cycles", cnt, 255);
        chk("timeout_fault", found, 1);
        repeat (3) @(negedge clock);
        chk("fault_holds_no_rd", {fault, mem_rd}, 2'b10);

        // clear during a load wait (0x05000000: load rd=r1 ra=r0)
        do_reset();
        ir = 32'h0500_0000; run = 1'b1; ack_mode = 1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock);
            if (iri) found = 1;
        end
        chk("load_fetch_done", found, 1);
        ack_mode = 2;
        repeat (4) @(negedge clock);
        chk("load_e1_waiting", {mem_rd, r0o, mari}, 3'b100);
        #2;
        clear = 1'b0;
        #1;
        chk("clear_async_zero", 32'(dut_v), 32'h0);
        tick();
        clear = 1'b1;
        @(negedge clock);
        chk("clear_release_idle", 32'(dut_v), 32'h0);
        @(negedge clock);
        chk("restart_f0", {pco, mari, pc_inc}, 3'b111);

        // halt is terminal
        tick();
        run = 1'b0; ack_mode = 1;
        do_reset();
        ir = 32'hF800_0000; run = 1'b1;
        tick();
        run = 1'b0;
        repeat (10) @(negedge clock);
        halt_v = '0;
        halt_v.halted = 1'b1;
        chk("halted_state", 32'(dut_v), 32'(halt_v));
        ack_mode = 0;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            run = $urandom_range(0, 1);
            @(negedge clock);
            if (dut_v !== halt_v) changes++;
        end
        chk("halt_ignores_inputs", changes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
